// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the video timing generator: adjust/flip
// controls in, counters, flip bus, blanking, sync and strobes out.
interface video_timing_gen_if #(
  parameter int H_W = 9
);
  logic           i_EMU_CLK6MPCEN_n;
  logic [1:0]     i_EMU_PXCNTR_ADJ_MODE;
  logic [1:0]     i_EMU_PXCNTR_ADJ_H;
  logic [2:0]     i_EMU_PXCNTR_ADJ_V;
  logic           i_FLIP;
  logic           i_CNTRSEL;
  logic [H_W-1:0] o_ABS_H_CNTR;
  logic [H_W-1:0] o_ABS_V_CNTR;
  logic           o_ABS_256H_n;
  logic           o_FLIP_64HA;
  logic [7:0]     o_FLIP_HV_BUS;
  logic           o_HBLANK;
  logic           o_VBLANK;
  logic           o_HSYNC_n;
  logic           o_VSYNC_n;
  logic           o_LINE_START;
  logic           o_FRAME_START;

  modport master (
    input  i_EMU_CLK6MPCEN_n,
    input  i_EMU_PXCNTR_ADJ_MODE,
    input  i_EMU_PXCNTR_ADJ_H,
    input  i_EMU_PXCNTR_ADJ_V,
    input  i_FLIP,
    input  i_CNTRSEL,
    output o_ABS_H_CNTR,
    output o_ABS_V_CNTR,
    output o_ABS_256H_n,
    output o_FLIP_64HA,
    output o_FLIP_HV_BUS,
    output o_HBLANK,
    output o_VBLANK,
    output o_HSYNC_n,
    output o_VSYNC_n,
    output o_LINE_START,
    output o_FRAME_START
  );

  modport slave (
    output i_EMU_CLK6MPCEN_n,
    output i_EMU_PXCNTR_ADJ_MODE,
    output i_EMU_PXCNTR_ADJ_H,
    output i_EMU_PXCNTR_ADJ_V,
    output i_FLIP,
    output i_CNTRSEL,
    input  o_ABS_H_CNTR,
    input  o_ABS_V_CNTR,
    input  o_ABS_256H_n,
    input  o_FLIP_64HA,
    input  o_FLIP_HV_BUS,
    input  o_HBLANK,
    input  o_VBLANK,
    input  o_HSYNC_n,
    input  o_VSYNC_n,
    input  o_LINE_START,
    input  o_FRAME_START
  );
endinterface

// File: rtl/video_timing_gen.sv
// H/V pixel counters with mid-line skip, blank/sync windows, line and
// frame strobes, and the flipped H/V bus for the tilemap/sprite blocks.
module video_timing_gen #(
  parameter int H_W          = 9,
  parameter int H_START      = 128,
  parameter int H_END        = 511,
  parameter int H_SKIP_BASE  = 227,
  parameter int H_SKIP_TO    = 228,
  parameter int V_START_BASE = 220,
  parameter int V_END        = 511,
  parameter int HBL_S        = 128,
  parameter int HBL_E        = 255,
  parameter int HS_S         = 176,
  parameter int HS_E         = 207,
  parameter int VBL_S        = 496,
  parameter int VBL_E        = 271,
  parameter int VS_S         = 232,
  parameter int VS_E         = 239,
  parameter int LATCH_PH     = 15
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST_n,
  video_timing_gen_if.master vt
);

  typedef logic [H_W-1:0] cnt_t;

  localparam cnt_t HST  = cnt_t'(H_START);
  localparam cnt_t HEND = cnt_t'(H_END);
  localparam cnt_t HSB  = cnt_t'(H_SKIP_BASE);
  localparam cnt_t HSKT = cnt_t'(H_SKIP_TO);
  localparam cnt_t VSB  = cnt_t'(V_START_BASE);
  localparam cnt_t VEND = cnt_t'(V_END);
  localparam cnt_t HBLS = cnt_t'(HBL_S);
  localparam cnt_t HBLE = cnt_t'(HBL_E);
  localparam cnt_t HSS  = cnt_t'(HS_S);
  localparam cnt_t HSE  = cnt_t'(HS_E);
  localparam cnt_t VBLS = cnt_t'(VBL_S);
  localparam cnt_t VBLE = cnt_t'(VBL_E);
  localparam cnt_t VSS  = cnt_t'(VS_S);
  localparam cnt_t VSE  = cnt_t'(VS_E);
  localparam logic [4:0] LPH = 5'(LATCH_PH);

  function automatic logic in_win(
    cnt_t x,
    cnt_t lo,
    cnt_t hi
  );
    return (x >= lo) && (x <= hi);
  endfunction

  // Vertical blank wraps through the frame start, so it is an OR window.
  function automatic logic vbl_win(cnt_t x);
    return (x >= VBLS) || (x <= VBLE);
  endfunction

  localparam logic HBL_RST = in_win(HST, HBLS, HBLE);
  localparam logic VBL_RST = vbl_win(VSB);
  localparam logic HSN_RST = !in_win(HST, HSS, HSE);
  localparam logic VSN_RST = !in_win(VSB, VSS, VSE);

  cnt_t       h_q, h_d;
  cnt_t       v_q, v_d;
  cnt_t       vst_q, vst_d;
  cnt_t       hsk_q, hsk_d;
  logic [7:0] vbus_q, vbus_d;
  logic       hbl_q, hbl_d;
  logic       vbl_q, vbl_d;
  logic       hsn_q, hsn_d;
  logic       vsn_q, vsn_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;

  cnt_t       vst_in;
  cnt_t       hsk_in;
  logic       pcen;
  logic       h_end;
  logic       v_end;
  logic       skip_hit;
  logic       flip;
  logic [7:0] hbus;

  assign pcen = ~vt.i_EMU_CLK6MPCEN_n;
  assign flip = vt.i_FLIP;

  always_comb begin
    vst_in = VSB;
    hsk_in = HSB;
    unique case (1'b1)
      vt.i_EMU_PXCNTR_ADJ_MODE == 2'd1: begin
        vst_in = VSB + cnt_t'(7);
        hsk_in = HSB - cnt_t'(8);
      end
      vt.i_EMU_PXCNTR_ADJ_MODE == 2'd2: begin
        vst_in = VSB + cnt_t'(vt.i_EMU_PXCNTR_ADJ_V);
        hsk_in = HSB - cnt_t'({vt.i_EMU_PXCNTR_ADJ_H, 1'b0});
      end
      default: ;
    endcase
  end

  assign h_end = (h_q == HEND);
  assign v_end = (v_q == VEND);
  // A skip point at or past the landing value degenerates to a straight count.
  assign skip_hit = (hsk_q < HSKT) && (h_q == hsk_q);

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    vst_d  = vst_q;
    hsk_d  = hsk_q;
    vbus_d = vbus_q;
    if (pcen) begin
      if (h_end && v_end) begin
        vst_d = vst_in;
        hsk_d = hsk_in;
      end
      if (h_end) begin
        h_d = HST;
        v_d = v_end ? vst_in : v_q + cnt_t'(1);
      end else if (skip_hit) begin
        h_d = HSKT;
      end else begin
        h_d = h_q + cnt_t'(1);
      end
      if (h_q[4:0] == LPH) begin
        vbus_d = v_q[7:0] ^ {8{flip}};
      end
    end
  end

  // Decoding the next counter values keeps these flops aligned with H/V.
  always_comb begin
    hbl_d = in_win(h_d, HBLS, HBLE);
    vbl_d = vbl_win(v_d);
    hsn_d = !in_win(h_d, HSS, HSE);
    vsn_d = !in_win(v_d, VSS, VSE);
    ls_d  = (h_d == HST);
    fs_d  = (h_d == HST) && (v_d == vst_d);
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      h_q    <= HST;
      v_q    <= VSB;
      vst_q  <= VSB;
      hsk_q  <= HSB;
      vbus_q <= '0;
      hbl_q  <= HBL_RST;
      vbl_q  <= VBL_RST;
      hsn_q  <= HSN_RST;
      vsn_q  <= VSN_RST;
      ls_q   <= 1'b1;
      fs_q   <= 1'b1;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      vst_q  <= vst_d;
      hsk_q  <= hsk_d;
      vbus_q <= vbus_d;
      hbl_q  <= hbl_d;
      vbl_q  <= vbl_d;
      hsn_q  <= hsn_d;
      vsn_q  <= vsn_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  // 64HA/128HA folding: bit 7 shows 128H in the right half, 64H in the left.
  assign hbus = {
    ((h_q[7] ^ flip) & h_q[8]) | ((h_q[6] ^ flip) & ~h_q[8]),
    h_q[6:0] ^ {7{flip}}
  };

  assign vt.o_ABS_H_CNTR  = h_q;
  assign vt.o_ABS_V_CNTR  = v_q;
  assign vt.o_ABS_256H_n  = ~h_q[8];
  assign vt.o_FLIP_64HA   = (h_q[6] ^ flip) & ~h_q[8];
  assign vt.o_FLIP_HV_BUS = vt.i_CNTRSEL ? hbus : vbus_q;
  assign vt.o_HBLANK      = hbl_q;
  assign vt.o_VBLANK      = vbl_q;
  assign vt.o_HSYNC_n     = hsn_q;
  assign vt.o_VSYNC_n     = vsn_q;
  assign vt.o_LINE_START  = ls_q;
  assign vt.o_FRAME_START = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen; a short V range keeps
// whole frames inside the cycle budget while H keeps its full line.
module tb_video_timing_gen;

  localparam int HS   = 128;
  localparam int HE   = 511;
  localparam int HSKB = 227;
  localparam int HSKT = 228;
  localparam int VSB  = 400;
  localparam int VE   = 423;
  localparam int VBLS = 420;
  localparam int VBLE = 402;
  localparam int VSS  = 408;
  localparam int VSE  = 411;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.H_W(9)) vif ();

  video_timing_gen #(
    .V_START_BASE(VSB),
    .V_END(VE),
    .VBL_S(VBLS),
    .VBL_E(VBLE),
    .VS_S(VSS),
    .VS_E(VSE)
  ) dut (
    .i_EMU_MCLK (clk),
    .i_EMU_RST_n(rst_n),
    .vt         (vif)
  );

  int checks = 0;
  int failures = 0;

  logic [33:0] q[$];
  logic [33:0] mon_e;

  int         m_vst, m_hsk, m_p, m_ln;
  logic [7:0] m_vbus;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
      if (failures >= 100) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  function automatic int seg1();
    return m_hsk - HS + 1;
  endfunction

  function automatic int line_len();
    if (m_hsk < HSKT) return seg1() + (HE - HSKT + 1);
    return HE - HS + 1;
  endfunction

  function automatic int h_of();
    if (m_hsk < HSKT && m_p >= seg1()) return HSKT + (m_p - seg1());
    return HS + m_p;
  endfunction

  function automatic int v_of();
    return m_vst + m_ln;
  endfunction

  task automatic load_set();
    m_vst = VSB;
    m_hsk = HSKB;
    if (vif.i_EMU_PXCNTR_ADJ_MODE == 2'd1) begin
      m_vst = VSB + 7;
      m_hsk = HSKB - 8;
    end else if (vif.i_EMU_PXCNTR_ADJ_MODE == 2'd2) begin
      m_vst = VSB + int'(vif.i_EMU_PXCNTR_ADJ_V);
      m_hsk = HSKB - 2 * int'(vif.i_EMU_PXCNTR_ADJ_H);
    end
  endtask

  task automatic model_step();
    logic [8:0] hh, vv;
    if (!rst_n) begin
      m_vst = VSB; m_hsk = HSKB;
      m_p = 0; m_ln = 0; m_vbus = 8'h00;
    end else if (!vif.i_EMU_CLK6MPCEN_n) begin
      hh = 9'(h_of());
      vv = 9'(v_of());
      if (hh[4:0] == 5'd15) m_vbus = vv[7:0] ^ {8{vif.i_FLIP}};
      m_p++;
      if (m_p == line_len()) begin
        m_p = 0;
        m_ln++;
        if (m_ln == VE - m_vst + 1) begin
          m_ln = 0;
          load_set();
        end
      end
    end
  endtask

  function automatic logic [33:0] expv();
    int h, v;
    logic [8:0] hh, vv;
    logic f;
    logic [7:0] hbus, bus;
    h = h_of();
    v = v_of();
    hh = 9'(h);
    vv = 9'(v);
    f = vif.i_FLIP;
    hbus = {((hh[7] ^ f) & hh[8]) | ((hh[6] ^ f) & ~hh[8]),
            hh[6:0] ^ {7{f}}};
    bus = vif.i_CNTRSEL ? hbus : m_vbus;
    return {hh, vv, ~hh[8], (hh[6] ^ f) & ~hh[8], bus,
            h >= 128 && h <= 255,
            v >= VBLS || v <= VBLE,
            !(h >= 176 && h <= 207),
            !(v >= VSS && v <= VSE),
            m_p == 0,
            m_p == 0 && m_ln == 0};
  endfunction

  function automatic logic [33:0] actv();
    return {vif.o_ABS_H_CNTR, vif.o_ABS_V_CNTR, vif.o_ABS_256H_n,
            vif.o_FLIP_64HA, vif.o_FLIP_HV_BUS, vif.o_HBLANK,
            vif.o_VBLANK, vif.o_HSYNC_n, vif.o_VSYNC_n,
            vif.o_LINE_START, vif.o_FRAME_START};
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("outputs", 64'(actv()), 64'(mon_e));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    q.push_back(expv());
    @(negedge clk);
    #1;
  endtask

  task automatic measure_line(int exp_len);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!vif.o_LINE_START && n < 2000);
    chk("line_len", 64'(n), 64'(exp_len));
  endtask

  task automatic measure_frame(int exp_lines);
    int n = 0;
    int l = 0;
    do begin
      cycle();
      n++;
      if (vif.o_LINE_START) l++;
    end while (!vif.o_FRAME_START && n < 20000);
    chk("frame_lines", 64'(l), 64'(exp_lines));
  endtask

  task automatic wait_frame_start();
    int n = 0;
    while (!vif.o_FRAME_START && n < 20000) begin
      cycle();
      n++;
    end
    chk("wait_frame", 64'(vif.o_FRAME_START), 64'(1));
  endtask

  task automatic wait_h(int target);
    int n = 0;
    while (h_of() != target && n < 2000) begin
      cycle();
      n++;
    end
    chk("wait_h", 64'(vif.o_ABS_H_CNTR), 64'(target));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vif.i_EMU_CLK6MPCEN_n = 1'b0;
    vif.i_EMU_PXCNTR_ADJ_MODE = 2'd0;
    vif.i_EMU_PXCNTR_ADJ_H = 2'd0;
    vif.i_EMU_PXCNTR_ADJ_V = 3'd0;
    vif.i_FLIP = 1'b0;
    vif.i_CNTRSEL = 1'b1;
    m_vst = VSB; m_hsk = HSKB; m_p = 0; m_ln = 0; m_vbus = 8'h00;

    for (int i = 0; i < 4; i++) begin
      vif.i_EMU_CLK6MPCEN_n = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("reset_h", 64'(vif.o_ABS_H_CNTR), 64'(HS));
    chk("reset_flags", 64'({vif.o_HBLANK, vif.o_VBLANK, vif.o_HSYNC_n,
        vif.o_VSYNC_n, vif.o_LINE_START, vif.o_FRAME_START}), 64'(6'h3f));

    rst_n = 1'b1;
    vif.i_EMU_CLK6MPCEN_n = 1'b0;
    measure_frame(VE - VSB + 1);
    measure_line(384);

    n = 0;
    while (v_of() != VSB + 10 && n < 12000) begin
      cycle();
      n++;
    end
    chk("wait_v", 64'(vif.o_ABS_V_CNTR), 64'(VSB + 10));
    vif.i_EMU_PXCNTR_ADJ_MODE = 2'd1;
    measure_line(384);
    wait_frame_start();
    chk("mode1_vstart", 64'(vif.o_ABS_V_CNTR), 64'(VSB + 7));
    measure_frame(VE - (VSB + 7) + 1);
    measure_line(376);

    vif.i_EMU_PXCNTR_ADJ_MODE = 2'd2;
    vif.i_EMU_PXCNTR_ADJ_H = 2'd3;
    vif.i_EMU_PXCNTR_ADJ_V = 3'd5;
    wait_frame_start();
    chk("mode2_vstart", 64'(vif.o_ABS_V_CNTR), 64'(VSB + 5));
    measure_line(378);

    for (int i = 0; i < 15000; i++) begin
      vif.i_EMU_CLK6MPCEN_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) vif.i_FLIP = ~vif.i_FLIP;
      if ($urandom_range(0, 9) == 0) vif.i_CNTRSEL = ~vif.i_CNTRSEL;
      if ($urandom_range(0, 2999) == 0) begin
        vif.i_EMU_PXCNTR_ADJ_MODE = 2'($urandom_range(0, 3));
        vif.i_EMU_PXCNTR_ADJ_H = 2'($urandom_range(0, 3));
        vif.i_EMU_PXCNTR_ADJ_V = 3'($urandom_range(0, 7));
      end
      cycle();
    end

    vif.i_EMU_CLK6MPCEN_n = 1'b0;
    vif.i_FLIP = 1'b1;
    vif.i_CNTRSEL = 1'b0;
    n = 0;
    while (!(h_of() == 143 && v_of() == 9'h1A5) && n < 15000) begin
      cycle();
      n++;
    end
    chk("wait_latch_v", 64'(vif.o_ABS_V_CNTR), 64'(9'h1A5));
    cycle();
    chk("vbus_latch", 64'(vif.o_FLIP_HV_BUS), 64'(8'h5A));
    for (int i = 0; i < 5; i++) cycle();
    chk("vbus_hold", 64'(vif.o_FLIP_HV_BUS), 64'(8'h5A));

    wait_h(HE);
    vif.i_EMU_CLK6MPCEN_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("cen_hold_h", 64'(vif.o_ABS_H_CNTR), 64'(HE));
    vif.i_EMU_CLK6MPCEN_n = 1'b0;
    cycle();
    chk("wrap_h", 64'(vif.o_ABS_H_CNTR), 64'(HS));

    wait_h(300);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({vif.o_ABS_H_CNTR, vif.o_ABS_V_CNTR, vif.o_HBLANK}),
        64'({9'(HS), 9'(VSB), 1'b1}));
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_h", 64'(vif.o_ABS_H_CNTR), 64'(HS + 1));
    for (int i = 0; i < 600; i++) begin
      vif.i_EMU_CLK6MPCEN_n = ($urandom_range(0, 3) == 0);
      vif.i_CNTRSEL = 1'($urandom_range(0, 1));
      cycle();
    end

    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
